// File: rtl/serial_word_receiver.sv
// serial_word_receiver
// Serial-in, parallel-out receiver. It frames a one-bit-per-clock stream into
// WIDTH-bit words, LSB first. A start pulse marks bit 0 of each frame.
// Each completed word is presented on a valid/ready output register.
// If a word completes while the output register still holds an unconsumed
// word, the new word is dropped and a sticky overrun flag is set.
//
// Ports:
//   clk        rising-edge clock for all state
//   reset      asynchronous, active-high; clears all state immediately
//   serial_in  serial data bit, sampled every edge while receiving
//   start      high in the cycle the frame's bit 0 is on serial_in
//   data_ready consumer accepts data_out on an edge with data_valid high
//   data_out   last completed word (bit i = i-th bit after start)
//   data_valid data_out holds an unconsumed word
//   busy       a frame is in progress
//   bit_count  bits captured in the current frame (0 when idle)
//   overrun    sticky; a completed word was dropped because output was full
module serial_word_receiver #(
    parameter  int WIDTH = 16,
    localparam int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             serial_in,
    input  logic             start,
    input  logic             data_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             busy,
    output logic [CW-1:0]    bit_count,
    output logic             overrun
);

    typedef enum logic {
        IDLE    = 1'b0,
        RECEIVE = 1'b1
    } state_t;

    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    state_t           state_r;
    logic [WIDTH-1:0] shreg_r;

    logic [WIDTH-1:0] word_s;
    logic             last_s;
    logic             complete_s;
    logic             out_free_s;

    // Completion detect and assembly of the finished word from the last bit.
    always_comb begin
        word_s     = {serial_in, shreg_r[WIDTH-2:0]};
        last_s     = (bit_count == LAST_IDX);
        // A start on the last-bit edge does not restart; the frame completes.
        complete_s = (state_r == RECEIVE) && last_s;
        // Output can take a new word if empty or being consumed on this edge.
        out_free_s = !data_valid || data_ready;
    end

    // Framing FSM, shift register and output holding register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            shreg_r    <= '0;
            bit_count  <= '0;
            busy       <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        shreg_r[0] <= serial_in;
                        bit_count  <= CW'(1);
                        busy       <= 1'b1;
                        state_r    <= RECEIVE;
                    end else begin
                        bit_count <= '0;
                        busy      <= 1'b0;
                    end
                end
                RECEIVE: begin
                    if (last_s) begin
                        bit_count <= '0;
                        busy      <= 1'b0;
                        state_r   <= IDLE;
                    end else if (start) begin
                        // Silent restart: partial frame discarded.
                        shreg_r[0] <= serial_in;
                        bit_count  <= CW'(1);
                    end else begin
                        shreg_r[bit_count] <= serial_in;
                        bit_count          <= bit_count + CW'(1);
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    bit_count <= '0;
                    busy      <= 1'b0;
                end
            endcase

            if (complete_s) begin
                if (out_free_s) begin
                    data_out   <= word_s;
                    data_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end else begin
                data_valid <= data_valid;
            end
        end
    end

endmodule
